// File: rtl/power_pkg.sv
// Shared power-management types: requested power states, sequencer states and
// the mapping of a requested state onto its power class (ON / GATED / OFF).
package power_pkg;

  typedef enum logic [2:0] {
    POWER_ACTIVE           = 3'd0,
    POWER_IDLE             = 3'd1,
    POWER_THERMAL_THROTTLE = 3'd2,
    POWER_SLEEP            = 3'd3,
    POWER_DEEP_SLEEP       = 3'd4
  } power_state_t;

  typedef enum logic [3:0] {
    ST_ON      = 4'd0,
    ST_GATED   = 4'd1,
    ST_OFF     = 4'd2,
    ST_ERR     = 4'd3,
    ST_CLK_OFF = 4'd4,
    ST_ISO     = 4'd5,
    ST_SAVE    = 4'd6,
    ST_PSW_OFF = 4'd7,
    ST_PSW_ON  = 4'd8,
    ST_RESTORE = 4'd9,
    ST_ISO_REL = 4'd10,
    ST_CLK_ON  = 4'd11
  } pwr_seq_state_t;

  typedef logic [1:0] pwr_class_t;

  localparam pwr_class_t PWR_CLASS_ON    = 2'd0;
  localparam pwr_class_t PWR_CLASS_GATED = 2'd1;
  localparam pwr_class_t PWR_CLASS_OFF   = 2'd2;

  function automatic pwr_class_t pwr_class(input power_state_t s);
    case (s)
      POWER_SLEEP:      pwr_class = PWR_CLASS_GATED;
      POWER_DEEP_SLEEP: pwr_class = PWR_CLASS_OFF;
      default:          pwr_class = PWR_CLASS_ON;
    endcase
  endfunction

endpackage

// File: rtl/power_throttle_gen.sv
// Thermal-throttle clock-enable generator: while enabled, emits a one-cycle
// enable every THROTTLE_DIV cycles, starting with the first enabled cycle.
module power_throttle_gen #(
  parameter int unsigned THROTTLE_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  output logic clk_pulse_o
);

  localparam logic [3:0] CntLast = 4'(THROTTLE_DIV - 1);

  logic [3:0] thr_cnt_q, thr_cnt_d;

  always_comb begin
    thr_cnt_d = 4'd0;
    if (enable_i) begin
      thr_cnt_d = (thr_cnt_q == CntLast) ? 4'd0 : thr_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      thr_cnt_q <= 4'd0;
    end else begin
      thr_cnt_q <= thr_cnt_d;
    end
  end

  assign clk_pulse_o = (thr_cnt_q == 4'd0);

endmodule

// File: rtl/power_domain_sequencer.sv
// Core power-domain sequencer: walks clock gate, isolation, retention and power
// switch through a handshaked order. Retention steps exist only with POWER_SEQ_RETENTION_EN.
module power_domain_sequencer
  import power_pkg::*;
#(
  parameter int unsigned CLK_SETTLE_CYCLES = 4,
  parameter int unsigned PSW_TIMEOUT       = 256,
  parameter int unsigned THROTTLE_DIV      = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  power_state_t target_state_i,
  input  logic         psw_ack_i,
  output logic         clk_en_o,
  output logic         iso_en_o,
  output logic         ret_save_o,
  output logic         ret_restore_o,
  output logic         psw_en_o,
  output power_state_t applied_state_o,
  output logic         seq_busy_o,
  output logic         seq_done_o,
  output logic         seq_error_o
);

`ifdef POWER_SEQ_RETENTION_EN
  localparam bit RetEn = 1'b1;
`else
  localparam bit RetEn = 1'b0;
`endif

  localparam logic [7:0]  SettleLast = 8'(CLK_SETTLE_CYCLES - 1);
  localparam logic [15:0] TmoLast    = 16'(PSW_TIMEOUT - 1);

  pwr_seq_state_t state_q, state_d;
  power_state_t   req_q, req_d, applied_q, applied_d;
  logic [7:0]     settle_q, settle_d;
  logic [15:0]    tmo_q, tmo_d;
  logic           done_q, done_d;
  pwr_class_t     tgt_class, req_class;
  logic           thr_en, thr_pulse;
  logic           from_transient, to_stable;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    applied_d = applied_q;
    settle_d  = 8'd0;
    tmo_d     = 16'd0;
    done_d    = 1'b0;
    tgt_class = pwr_class(target_state_i);
    req_class = pwr_class(req_q);
    case (state_q)
      ST_ON: begin
        if (tgt_class != PWR_CLASS_ON) begin
          req_d   = target_state_i;
          state_d = ST_CLK_OFF;
        end else begin
          applied_d = target_state_i;
        end
      end
      ST_GATED: begin
        if (tgt_class != PWR_CLASS_GATED) begin
          req_d   = target_state_i;
          state_d = (tgt_class == PWR_CLASS_OFF) ? ST_ISO : ST_CLK_ON;
        end
      end
      // ERR only accepts a way back up; OFF-class requests leave it parked
      ST_OFF, ST_ERR: begin
        if (tgt_class != PWR_CLASS_OFF) begin
          req_d   = target_state_i;
          state_d = ST_PSW_ON;
        end
      end
      ST_CLK_OFF: begin
        if (settle_q == SettleLast) begin
          state_d = (req_class == PWR_CLASS_GATED) ? ST_GATED : ST_ISO;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_ISO:  state_d = RetEn ? ST_SAVE : ST_PSW_OFF;
      ST_SAVE: state_d = ST_PSW_OFF;
      // the timeout counter only advances while ack still disagrees with psw_en
      ST_PSW_OFF: begin
        if (!psw_ack_i) begin
          state_d = ST_OFF;
        end else if (tmo_q == TmoLast) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_PSW_ON: begin
        if (psw_ack_i) begin
          state_d = RetEn ? ST_RESTORE : ST_ISO_REL;
        end else if (tmo_q == TmoLast) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_RESTORE: state_d = ST_ISO_REL;
      ST_ISO_REL: state_d = (req_class == PWR_CLASS_ON) ? ST_CLK_ON : ST_GATED;
      ST_CLK_ON: begin
        if (settle_q == SettleLast) begin
          state_d = ST_ON;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      default: state_d = ST_ON;
    endcase
    from_transient = !(state_q inside {ST_ON, ST_GATED, ST_OFF, ST_ERR});
    to_stable      = state_d inside {ST_ON, ST_GATED, ST_OFF};
    if (from_transient && to_stable) begin
      done_d    = 1'b1;
      applied_d = req_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_ON;
      req_q     <= POWER_ACTIVE;
      applied_q <= POWER_ACTIVE;
      settle_q  <= 8'd0;
      tmo_q     <= 16'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      applied_q <= applied_d;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
    end
  end

  assign thr_en = (state_q == ST_ON) && (applied_q == POWER_THERMAL_THROTTLE);

  power_throttle_gen #(
    .THROTTLE_DIV(THROTTLE_DIV)
  ) u_throttle (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (thr_en),
    .clk_pulse_o(thr_pulse)
  );

  always_comb begin
    clk_en_o   = 1'b0;
    iso_en_o   = 1'b0;
    psw_en_o   = 1'b1;
    seq_busy_o = 1'b1;
    case (state_q)
      ST_ON: begin
        clk_en_o   = thr_en ? thr_pulse : 1'b1;
        seq_busy_o = 1'b0;
      end
      ST_GATED: seq_busy_o = 1'b0;
      ST_OFF: begin
        iso_en_o   = 1'b1;
        psw_en_o   = 1'b0;
        seq_busy_o = 1'b0;
      end
      ST_ERR: begin
        iso_en_o   = 1'b1;
        seq_busy_o = 1'b0;
      end
      ST_CLK_OFF: clk_en_o = 1'b0;
      ST_CLK_ON:  clk_en_o = 1'b1;
      ST_PSW_OFF: begin
        iso_en_o = 1'b1;
        psw_en_o = 1'b0;
      end
      ST_ISO, ST_SAVE, ST_PSW_ON, ST_RESTORE, ST_ISO_REL: iso_en_o = 1'b1;
      default: seq_busy_o = 1'b1;
    endcase
  end

  assign ret_save_o      = RetEn && (state_q == ST_SAVE);
  assign ret_restore_o   = RetEn && (state_q == ST_RESTORE);
  assign applied_state_o = applied_q;
  assign seq_done_o      = done_q;
  assign seq_error_o     = (state_q == ST_ERR);

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench for power_domain_sequencer; expectations follow the retention
// build when POWER_SEQ_RETENTION_EN is defined.
module tb_power_domain_sequencer;
  import power_pkg::*;

`ifdef POWER_SEQ_RETENTION_EN
  localparam int Ret = 1;
`else
  localparam int Ret = 0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni;
  power_state_t target_state_i;
  logic         psw_ack_i;
  logic         clk_en_o, iso_en_o, ret_save_o, ret_restore_o, psw_en_o;
  power_state_t applied_state_o;
  logic         seq_busy_o, seq_done_o, seq_error_o;

  int   vectors = 0;
  int   miscompares = 0;
  logic ackFollow = 1'b1;
  logic ackLevel = 1'b1;
  logic [3:0] ackHist = 4'hF;

  power_domain_sequencer #(
    .CLK_SETTLE_CYCLES(4),
    .PSW_TIMEOUT(256),
    .THROTTLE_DIV(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .target_state_i (target_state_i),
    .psw_ack_i      (psw_ack_i),
    .clk_en_o       (clk_en_o),
    .iso_en_o       (iso_en_o),
    .ret_save_o     (ret_save_o),
    .ret_restore_o  (ret_restore_o),
    .psw_en_o       (psw_en_o),
    .applied_state_o(applied_state_o),
    .seq_busy_o     (seq_busy_o),
    .seq_done_o     (seq_done_o),
    .seq_error_o    (seq_error_o)
  );

  always #5 clk_i = ~clk_i;

  // ack either follows psw_en three cycles late or sits at a forced level
  task automatic tick();
    @(posedge clk_i);
    #1;
    ackHist   = {ackHist[2:0], psw_en_o};
    psw_ack_i = ackFollow ? ackHist[3] : ackLevel;
  endtask

  function automatic logic [6:0] outs();
    return {clk_en_o, iso_en_o, ret_save_o, ret_restore_o, psw_en_o, seq_busy_o, seq_done_o};
  endfunction

  task automatic test_reset();
    logic [7:0] obs;
    rst_ni = 1'b0;
    target_state_i = POWER_ACTIVE;
    psw_ack_i = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      obs = {outs(), seq_error_o};
      vectors++;
      if (obs !== 8'b10001000 || applied_state_o !== POWER_ACTIVE) begin
        miscompares++;
        $display("[TB] FAIL reset k=%0d got %b/%s expected 10001000/POWER_ACTIVE", k, obs, applied_state_o.name());
      end
      if (k == 0) rst_ni = 1'b1;
      tick();
    end
  endtask

  task automatic test_gated();
    logic [6:0] exp;
    target_state_i = POWER_SLEEP;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k < 5) ? 7'b0000110 : 7'b0000101;
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("[TB] FAIL on_to_gated k=%0d got %b expected %b", k, outs(), exp);
      end
    end
    vectors++;
    if (applied_state_o !== POWER_SLEEP) begin
      miscompares++;
      $display("[TB] FAIL gated_applied got %s expected POWER_SLEEP", applied_state_o.name());
    end
    target_state_i = POWER_ACTIVE;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k < 5) ? 7'b1000110 : 7'b1000101;
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("[TB] FAIL gated_to_on k=%0d got %b expected %b", k, outs(), exp);
      end
    end
    vectors++;
    if (applied_state_o !== POWER_ACTIVE) begin
      miscompares++;
      $display("[TB] FAIL on_applied got %s expected POWER_ACTIVE", applied_state_o.name());
    end
  endtask

  task automatic test_deep_sleep();
    logic [6:0] exp;
    ackFollow = 1'b1;
    target_state_i = POWER_DEEP_SLEEP;
    for (int k = 1; k <= 10 + Ret; k++) begin
      tick();
      if (k <= 4) exp = 7'b0000110;
      else if (k == 5) exp = 7'b0100110;
      else if (Ret == 1 && k == 6) exp = 7'b0110110;
      else if (k == 10 + Ret) exp = 7'b0100001;
      else exp = 7'b0100010;
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("[TB] FAIL on_to_off k=%0d got %b expected %b", k, outs(), exp);
      end
    end
    tick();
    vectors++;
    if (outs() !== 7'b0100000 || applied_state_o !== POWER_DEEP_SLEEP) begin
      miscompares++;
      $display("[TB] FAIL off_stable got %b/%s expected 0100000/POWER_DEEP_SLEEP", outs(), applied_state_o.name());
    end
    target_state_i = POWER_ACTIVE;
    for (int k = 1; k <= 10 + Ret; k++) begin
      tick();
      if (k <= 4) exp = 7'b0100110;
      else if (Ret == 1 && k == 5) exp = 7'b0101110;
      else if (k == 5 + Ret) exp = 7'b0100110;
      else if (k == 10 + Ret) exp = 7'b1000101;
      else exp = 7'b1000110;
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("[TB] FAIL off_to_on k=%0d got %b expected %b", k, outs(), exp);
      end
    end
  endtask

  task automatic waitDone(input string name, input power_state_t expApplied);
    int n = 0;
    while (!seq_done_o && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (!seq_done_o || applied_state_o !== expApplied) begin
      miscompares++;
      $display("[TB] FAIL %s done=%b applied=%s expected done=1 applied=%s", name, seq_done_o, applied_state_o.name(), expApplied.name());
    end
  endtask

  task automatic test_back_to_back();
    target_state_i = POWER_SLEEP;
    tick();
    tick();
    target_state_i = POWER_DEEP_SLEEP;
    tick();
    tick();
    tick();
    vectors++;
    if (outs() !== 7'b0000101 || applied_state_o !== POWER_SLEEP) begin
      miscompares++;
      $display("[TB] FAIL b2b_gated got %b/%s expected 0000101/POWER_SLEEP", outs(), applied_state_o.name());
    end
    tick();
    vectors++;
    if (outs() !== 7'b0100110) begin
      miscompares++;
      $display("[TB] FAIL b2b_iso got %b expected 0100110", outs());
    end
    waitDone("b2b_off", POWER_DEEP_SLEEP);
    target_state_i = POWER_ACTIVE;
    tick();
    waitDone("b2b_on", POWER_ACTIVE);
  endtask

  task automatic test_throttle();
    logic [2:0] exp;
    target_state_i = POWER_THERMAL_THROTTLE;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k % 4 == 1) ? 3'b100 : 3'b000;
      vectors++;
      if ({clk_en_o, seq_busy_o, seq_done_o} !== exp || applied_state_o !== POWER_THERMAL_THROTTLE) begin
        miscompares++;
        $display("[TB] FAIL throttle k=%0d got %b/%s expected %b/POWER_THERMAL_THROTTLE", k, {clk_en_o, seq_busy_o, seq_done_o}, applied_state_o.name(), exp);
      end
    end
    target_state_i = POWER_ACTIVE;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if ({clk_en_o, seq_busy_o, seq_done_o} !== 3'b100 || applied_state_o !== POWER_ACTIVE) begin
        miscompares++;
        $display("[TB] FAIL unthrottle k=%0d got %b/%s expected 100/POWER_ACTIVE", k, {clk_en_o, seq_busy_o, seq_done_o}, applied_state_o.name());
      end
    end
  endtask

  task automatic test_timeout();
    logic [4:0] obs;
    ackFollow = 1'b0;
    ackLevel  = 1'b1;
    target_state_i = POWER_DEEP_SLEEP;
    for (int k = 1; k <= 261 + Ret; k++) tick();
    vectors++;
    if (seq_error_o !== 1'b0 || psw_en_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tmo_last_wait got err=%b psw=%b expected err=0 psw=0", seq_error_o, psw_en_o);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      obs = {clk_en_o, iso_en_o, psw_en_o, seq_busy_o, seq_error_o};
      vectors++;
      if (obs !== 5'b01101) begin
        miscompares++;
        $display("[TB] FAIL tmo_err k=%0d got %b expected 01101", k, obs);
      end
    end
    target_state_i = POWER_ACTIVE;
    tick();
    obs = {clk_en_o, iso_en_o, psw_en_o, seq_busy_o, seq_error_o};
    vectors++;
    if (obs !== 5'b01110) begin
      miscompares++;
      $display("[TB] FAIL tmo_exit got %b expected 01110", obs);
    end
    waitDone("tmo_recover", POWER_ACTIVE);
    vectors++;
    if (clk_en_o !== 1'b1 || seq_error_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tmo_final got clk=%b err=%b expected clk=1 err=0", clk_en_o, seq_error_o);
    end
    ackFollow = 1'b1;
  endtask

  task automatic test_reset_mid();
    target_state_i = POWER_DEEP_SLEEP;
    for (int k = 0; k < 6; k++) tick();
    rst_ni = 1'b0;
    target_state_i = POWER_ACTIVE;
    #1;
    vectors++;
    if ({outs(), seq_error_o} !== 8'b10001000 || applied_state_o !== POWER_ACTIVE) begin
      miscompares++;
      $display("[TB] FAIL reset_mid got %b/%s expected 10001000/POWER_ACTIVE", {outs(), seq_error_o}, applied_state_o.name());
    end
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    vectors++;
    if ({outs(), seq_error_o} !== 8'b10001000) begin
      miscompares++;
      $display("[TB] FAIL after_reset_mid got %b expected 10001000", {outs(), seq_error_o});
    end
  endtask

  initial begin
    test_reset();
    test_gated();
    test_deep_sleep();
    test_back_to_back();
    test_throttle();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence of tests completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
